// File: rtl/timer_counter.sv
// Memory-mapped down-counting timer with one-shot / auto-reload modes and a maskable irq.
// Define TIMER_BE_EN to enable per-byte write merging on CTRL/PRESET.
module timer_counter #(
  parameter int WIDTH = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  addr,
  input  logic [3:0]  be,
  input  logic [31:0] wd,
  input  logic        we,
  output logic [31:0] rd,
  output logic        irq
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_CNT  = 2'd2,
    S_INT  = 2'd3
  } state_e;

  localparam logic [1:0] A_CTRL   = 2'd0;
  localparam logic [1:0] A_PRESET = 2'd1;
  localparam logic [1:0] A_COUNT  = 2'd2;

  // ctrl_q = {IM, MODE[1:0], EN}
  logic [3:0]       ctrl_q, ctrl_d;
  logic [WIDTH-1:0] preset_q, preset_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic             irq_flag_q, irq_flag_d;
  state_e           state_q, state_d;

  logic        ctrl_en, ctrl_im, auto_reload;
  logic        wr_ctrl, wr_preset, sw_clr;
  logic        fsm_en_clr, fsm_irq_set, fsm_irq_clr;
  logic [31:0] wmask;
  logic [31:0] ctrl_wr_val, preset_wr_val;

  assign ctrl_en     = ctrl_q[0];
  assign ctrl_im     = ctrl_q[3];
  assign auto_reload = (ctrl_q[2:1] == 2'b01);

  assign wr_ctrl   = we && (addr == A_CTRL);
  assign wr_preset = we && (addr == A_PRESET);

`ifdef TIMER_BE_EN
  always_comb begin
    for (int i = 0; i < 4; i++) wmask[8*i +: 8] = {8{be[i]}};
  end
  assign sw_clr = (wr_ctrl || wr_preset) && (be != 4'b0000);
`else
  logic unused_be;
  assign unused_be = ^be;
  assign wmask     = 32'hFFFF_FFFF;
  assign sw_clr    = wr_ctrl || wr_preset;
`endif

  assign ctrl_wr_val   = (wd & wmask) | ({28'd0, ctrl_q} & ~wmask);
  assign preset_wr_val = (wd & wmask) | (32'(preset_q) & ~wmask);

  // Counter FSM: decisions use the pre-edge CTRL/PRESET contents.
  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    fsm_en_clr  = 1'b0;
    fsm_irq_set = 1'b0;
    fsm_irq_clr = 1'b0;
    case (state_q)
      S_IDLE: if (ctrl_en) state_d = S_LOAD;
      S_LOAD: begin
        count_d = preset_q;
        state_d = S_CNT;
      end
      S_CNT: begin
        if (!ctrl_en) begin
          state_d = S_IDLE;
        end else if (count_q != '0) begin
          count_d = count_q - WIDTH'(1);
        end else begin
          state_d     = S_INT;
          fsm_irq_set = 1'b1;
        end
      end
      S_INT: begin
        if (auto_reload) begin
          fsm_irq_clr = 1'b1;
          state_d     = S_LOAD;
        end else begin
          fsm_en_clr = 1'b1;
          state_d    = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Register file; a software CTRL write overrides the one-shot EN clear.
  always_comb begin
    ctrl_d   = ctrl_q;
    preset_d = preset_q;
    if (fsm_en_clr) ctrl_d[0] = 1'b0;
    if (wr_ctrl)    ctrl_d    = ctrl_wr_val[3:0];
    if (wr_preset)  preset_d  = WIDTH'(preset_wr_val);
  end

  // A fresh terminal count wins over a same-edge clear so no interrupt is lost.
  always_comb begin
    irq_flag_d = irq_flag_q;
    if (sw_clr || fsm_irq_clr) irq_flag_d = 1'b0;
    if (fsm_irq_set)           irq_flag_d = 1'b1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      ctrl_q     <= '0;
      preset_q   <= '0;
      count_q    <= '0;
      irq_flag_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      ctrl_q     <= ctrl_d;
      preset_q   <= preset_d;
      count_q    <= count_d;
      irq_flag_q <= irq_flag_d;
    end
  end

  always_comb begin
    rd = 32'd0;
    case (addr)
      A_CTRL:   rd = {28'd0, ctrl_q};
      A_PRESET: rd = 32'(preset_q);
      A_COUNT:  rd = 32'(count_q);
      default:  rd = 32'd0;
    endcase
  end

  assign irq = irq_flag_q & ctrl_im;

endmodule

// File: tb/tb_timer_counter.sv
// Directed bench for timer_counter: reset, one-shot, auto-reload, mask/pause, boundaries, byte enables.
module tb_timer_counter;

  logic        clk;
  logic        reset;
  logic [1:0]  addr;
  logic [3:0]  be;
  logic [31:0] wd;
  logic        we;
  logic [31:0] rd;
  logic        irq;

  int passed = 0;
  int total  = 0;

  timer_counter #(.WIDTH(32)) dut (
    .clk(clk), .reset(reset), .addr(addr), .be(be),
    .wd(wd), .we(we), .rd(rd), .irq(irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total = total + 1;
    assert (got === exp) passed = passed + 1;
    else $error("FAIL %s: observed %h expected %h", tag, got, exp);
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Write lands on the next rising edge; returns 1 time unit after it.
  task automatic wr(input logic [1:0] a, input logic [31:0] d, input logic [3:0] b);
    addr = a; wd = d; be = b; we = 1'b1;
    @(posedge clk);
    #1;
    we = 1'b0; be = 4'hF; wd = 32'd0;
  endtask

  task automatic chk_rd(input string tag, input logic [1:0] a, input logic [31:0] exp);
    addr = a;
    #1;
    chk(tag, rd, exp);
  endtask

  initial begin
    reset = 1'b0; addr = 2'd0; be = 4'hF; wd = 32'd0; we = 1'b0;
    #12;
    chk_rd("rst_ctrl", 2'd0, 32'd0);
    chk_rd("rst_preset", 2'd1, 32'd0);
    chk_rd("rst_count", 2'd2, 32'd0);
    chk_rd("rst_rsvd", 2'd3, 32'd0);
    chk("rst_irq", {31'd0, irq}, 32'd0);
    reset = 1'b1;
    tick(1);

    // One-shot, PRESET=5: irq at edge 8 after the CTRL write, held until a CTRL write
    wr(2'd1, 32'd5, 4'hF);
    wr(2'd0, 32'h9, 4'hF);
    tick(2);
    chk_rd("os_count_load", 2'd2, 32'd5);
    tick(5);
    chk_rd("os_count_zero", 2'd2, 32'd0);
    chk("os_irq_e7", {31'd0, irq}, 32'd0);
    tick(1);
    chk("os_irq_e8", {31'd0, irq}, 32'd1);
    chk_rd("os_ctrl_int", 2'd0, 32'h9);
    tick(1);
    chk_rd("os_ctrl_en_clr", 2'd0, 32'h8);
    tick(2);
    chk("os_irq_hold", {31'd0, irq}, 32'd1);
    wr(2'd0, 32'h8, 4'hF);
    chk("os_irq_clr", {31'd0, irq}, 32'd0);

    // Reset mid-count aborts with no irq
    wr(2'd1, 32'd5, 4'hF);
    wr(2'd0, 32'h9, 4'hF);
    tick(3);
    chk_rd("mid_count4", 2'd2, 32'd4);
    #2 reset = 1'b0;
    chk_rd("mid_rst_ctrl", 2'd0, 32'd0);
    chk_rd("mid_rst_preset", 2'd1, 32'd0);
    chk_rd("mid_rst_count", 2'd2, 32'd0);
    chk_rd("mid_rst_rsvd", 2'd3, 32'd0);
    chk("mid_rst_irq", {31'd0, irq}, 32'd0);
    reset = 1'b1;
    tick(10);
    chk("mid_rst_noirq", {31'd0, irq}, 32'd0);
    chk_rd("mid_rst_count_idle", 2'd2, 32'd0);

    // Auto-reload, PRESET=2: 1-cycle pulse every 5 cycles, COUNT 2,1,0
    wr(2'd1, 32'd2, 4'hF);
    wr(2'd0, 32'hB, 4'hF);
    tick(2);
    chk_rd("ar_c2", 2'd2, 32'd2);
    tick(1);
    chk_rd("ar_c1", 2'd2, 32'd1);
    tick(1);
    chk_rd("ar_c0", 2'd2, 32'd0);
    chk("ar_irq_pre", {31'd0, irq}, 32'd0);
    tick(1);
    chk("ar_irq_p1", {31'd0, irq}, 32'd1);
    tick(1);
    chk("ar_irq_p1_end", {31'd0, irq}, 32'd0);
    tick(1);
    chk_rd("ar_c2b", 2'd2, 32'd2);
    tick(1);
    chk_rd("ar_c1b", 2'd2, 32'd1);
    tick(1);
    chk_rd("ar_c0b", 2'd2, 32'd0);
    chk("ar_irq_pre2", {31'd0, irq}, 32'd0);
    tick(1);
    chk("ar_irq_p2", {31'd0, irq}, 32'd1);
    chk_rd("ar_ctrl_kept", 2'd0, 32'hB);
    tick(1);
    chk("ar_irq_p2_end", {31'd0, irq}, 32'd0);
    wr(2'd0, 32'h0, 4'hF);
    tick(3);

    // Masked: COUNT reaches 0, irq stays low, EN cleared after INT
    wr(2'd1, 32'd3, 4'hF);
    wr(2'd0, 32'h1, 4'hF);
    tick(5);
    chk_rd("mask_c0", 2'd2, 32'd0);
    tick(1);
    chk("mask_irq", {31'd0, irq}, 32'd0);
    tick(1);
    chk_rd("mask_ctrl", 2'd0, 32'h0);

    // Pause at COUNT=2, then resume with a fresh reload
    wr(2'd0, 32'h1, 4'hF);
    tick(2);
    chk_rd("pause_c3", 2'd2, 32'd3);
    wr(2'd0, 32'h0, 4'hF);
    tick(3);
    chk_rd("pause_frozen", 2'd2, 32'd2);
    wr(2'd0, 32'h1, 4'hF);
    tick(1);
    chk_rd("resume_load", 2'd2, 32'd2);
    tick(1);
    chk_rd("resume_reload", 2'd2, 32'd3);
    wr(2'd0, 32'h0, 4'hF);
    tick(3);

    // PRESET=0: irq at edge 3; CTRL write of 0x9 in the INT cycle keeps EN
    wr(2'd1, 32'd0, 4'hF);
    wr(2'd0, 32'h9, 4'hF);
    tick(2);
    chk("p0_irq_e2", {31'd0, irq}, 32'd0);
    tick(1);
    chk("p0_irq_e3", {31'd0, irq}, 32'd1);
    wr(2'd0, 32'h9, 4'hF);
    chk_rd("int_wr_ctrl", 2'd0, 32'h9);
    chk("int_wr_irq", {31'd0, irq}, 32'd0);
    tick(2);
    chk("rerun_irq_e2", {31'd0, irq}, 32'd0);
    tick(1);
    chk("rerun_irq_e3", {31'd0, irq}, 32'd1);
    wr(2'd0, 32'h0, 4'hF);
    chk("stop_irq", {31'd0, irq}, 32'd0);
    tick(2);

    // COUNT and reserved writes are ignored
    wr(2'd2, 32'h1234, 4'hF);
    chk_rd("count_ro", 2'd2, 32'd0);
    wr(2'd3, 32'hFFFF_FFFF, 4'hF);
    chk_rd("rsvd_rd0", 2'd3, 32'd0);

    // Byte-enable merge on PRESET
    wr(2'd1, 32'hAABB_CCDD, 4'hF);
    chk_rd("be_full", 2'd1, 32'hAABB_CCDD);
    wr(2'd1, 32'h1122_3344, 4'b0101);
`ifdef TIMER_BE_EN
    chk_rd("be_merge", 2'd1, 32'hAA22_CC44);
`else
    chk_rd("be_merge", 2'd1, 32'h1122_3344);
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/timer_counter.md
# timer_counter

Memory-mapped timer/counter peripheral on the processor-side bridge bus. It is the responder for the CPU's Pr* address/byte-enable/write-data/write-enable requests. It returns read data combinationally in the same cycle and drives one interrupt line into `HWInt[2]`. It counts down from a programmable preset and runs in one-shot or auto-reload mode.

## Interface
- `WIDTH`, default 32: width of PRESET and COUNT.
- `clk` input 1: single clock; all state changes on the rising edge.
- `reset` input 1: asynchronous, active-low reset.
- `addr` input 2: word select, driven from bridge `Praddr[3:2]`.
- `be` input 4: byte enables, driven from `PrBE`.
- `wd` input 32: write data, driven from `PrWD`.
- `we` input 1: write strobe, already gated by the bridge address decode.
- `rd` output 32: read data, combinational from `addr`.
- `irq` output 1: registered interrupt request.

## Operation
Register map (`addr`):
- 0: CTRL.
  - [0] EN.
  - [2:1] MODE: 00 one-shot, 01 auto-reload, 1x behaves as 00.
  - [3] IM, interrupt mask, 1 = enabled.
  - [31:4] read 0.
- 1: PRESET, read/write.
- 2: COUNT, read-only; writes ignored.
- 3: reserved; reads 0, writes ignored.

Writes:
- Take effect at the clock edge where `we`=1.
- A write to CTRL or PRESET clears `irq_flag`.

FSM states IDLE, LOAD, CNT, INT:
- IDLE: EN=1 -> LOAD; else stay. COUNT holds.
- LOAD: COUNT <= PRESET -> CNT.
- CNT:
  - EN=0 -> IDLE; COUNT frozen.
  - COUNT≠0: COUNT <= COUNT-1.
  - COUNT==0: -> INT; `irq_flag` <= 1.
- INT, MODE 00: EN <= 0 -> IDLE; `irq_flag` stays set until a software write to CTRL/PRESET.
- INT, MODE 01: `irq_flag` <= 0 -> LOAD.

Outputs and arithmetic:
- `irq` = `irq_flag` & IM.
- Decrement is modulo 2^WIDTH. It never underflows because 0 is detected first.

Simultaneous events:
- A software CTRL write in the same cycle as the INT-state EN clear: the software value wins.
- The FSM samples pre-edge CTRL/PRESET values.
- A PRESET write during CNT does not affect COUNT until the next LOAD.
- Writing EN=1 while in CNT does not restart the count.
- Writing EN=0 then EN=1 resumes via IDLE->LOAD, i.e. a fresh reload.

PRESET=0: LOAD->CNT with COUNT=0, then INT on the next edge.

## Timing
Reset (`reset`=0, asynchronous):
- CTRL=0, PRESET=0, COUNT=0, state IDLE, `irq_flag`=0, `irq`=0.
- `rd`=0 for every `addr`.
- Reset mid-count aborts immediately; no irq is generated.

Latencies:
- `rd` has zero latency (combinational); the bridge captures it into the M/W pipeline register.
- EN written at edge E0: IDLE->LOAD at E1, COUNT=PRESET at E2, COUNT=0 at E2+P, INT with `irq`=1 at E3+P.
- First irq therefore comes P+3 edges after the enabling write.
- Auto-reload period: P+3 cycles. `irq` is high for exactly 1 cycle per period.
- One-shot: `irq` stays high until a CTRL/PRESET write; it is low the cycle after that write edge.

## Configuration
- `TIMER_BE_EN` defined: writes merge per byte; only bytes with `be[i]`=1 update [8i+7:8i] of CTRL/PRESET. Any write with `be`≠0 clears `irq_flag`.
- `TIMER_BE_EN` undefined: `be` is ignored; every write replaces the full word.

## Test plan
- Reset: drive `reset`=0 mid-count with PRESET=5 -> `rd`=0 at all addresses, `irq`=0, state IDLE, COUNT=0.
- One-shot: PRESET=5, then CTRL=0x9 (EN, IM, mode 0) -> `irq` rises at edge 8 after the CTRL write and holds. CTRL reads 0x8. A later CTRL write of 0x8 drops `irq` next cycle.
- Auto-reload: PRESET=2, CTRL=0xB -> `irq` 1-cycle pulses every 5 cycles; COUNT reads sequence 2,1,0.
- Mask and pause:
  - CTRL=0x1 with PRESET=3 -> `irq` stays 0 while COUNT still reaches 0.
  - Writing EN=0 at COUNT=2 freezes COUNT=2.
  - Writing EN=1 reloads to PRESET.
- Boundary:
  - PRESET=0, CTRL=0x9 -> `irq` at edge 3.
  - A COUNT write of 0x1234 is ignored.
  - `addr`=3 reads 0.
  - A CTRL write in the INT cycle with 0x9 keeps EN=1.
- Byte enables (`TIMER_BE_EN`): PRESET=0xAABBCCDD, then write 0x11223344 with `be`=0101 -> PRESET=0xAA22CC44. Without the macro -> 0x11223344.
